// File: rtl/serial_display_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module : serial_display_receiver_pkg
// Brief  : Display-bus geometry defaults, event/status types, width helper.
// Rev    : 1.0 - initial release
// ============================================================================
package serial_display_receiver_pkg;

    localparam int DIGIT_COUNT         = 6;
    localparam int SEGMENT_COUNT       = 8;
    localparam int DEFAULT_SHIFT_WIDTH = DIGIT_COUNT * SEGMENT_COUNT;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Serial-bus activity seen in one system clock cycle: {latch, shift}.
    typedef enum logic [1:0] {
        EV_NONE        = 2'b00,
        EV_SHIFT       = 2'b01,
        EV_LATCH       = 2'b10,
        EV_SHIFT_LATCH = 2'b11
    } bus_event_e;

    typedef struct packed {
        logic valid;
        logic frame_err;
        logic overrun;
    } rx_status_t;

    // Room for SHIFT_WIDTH+1 so an over-long frame is distinguishable.
    function automatic int count_width(input int shift_width);
        return $clog2(shift_width + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_display_receiver_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : serial_display_receiver_sync_edge_detect
// Brief  : Multi-flop synchroniser with one-flop rising-edge detector.
// Rev    : 1.0 - initial release
// ============================================================================
module serial_display_receiver_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], i_async};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = chain[SYNC_STAGES-1];
    assign o_rise = o_sync & ~prev;

endmodule
`default_nettype wire

// File: rtl/serial_display_receiver.sv
`default_nettype none
// ============================================================================
// Module : serial_display_receiver
// Brief  : Oversampling multi-channel display shift-bus receiver with latch,
//          valid/ack handshake, framing-error and overrun flags.
// Rev    : 1.0 - initial release
// ============================================================================
module serial_display_receiver
    import serial_display_receiver_pkg::*;
#(
    parameter int SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH,
    parameter int CHANNELS    = 1,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_en,
    input  logic                            i_serial_clk,
    input  logic                            i_serial_latch,
    input  logic [CHANNELS-1:0]             i_serial_data,
    input  logic                            i_ack,
    output logic [CHANNELS*SHIFT_WIDTH-1:0] o_parallel_data,
    output logic                            o_valid,
    output logic                            o_frame_err,
    output logic                            o_overrun
);

    localparam int               CNT_W      = count_width(SHIFT_WIDTH);
    localparam int               DATA_W     = CHANNELS * SHIFT_WIDTH;
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(SHIFT_WIDTH);
    localparam logic [CNT_W-1:0] COUNT_MAX  = {CNT_W{1'b1}};

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    logic clk_sync;
    logic clk_rise;
    logic latch_sync;
    logic latch_rise;
    logic unused_sync_levels;

    serial_display_receiver_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .i_clk     (i_clk),
        .i_reset_n (rst_n),
        .i_async   (i_serial_clk),
        .o_sync    (clk_sync),
        .o_rise    (clk_rise)
    );

    serial_display_receiver_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_latch_sync (
        .i_clk     (i_clk),
        .i_reset_n (rst_n),
        .i_async   (i_serial_latch),
        .o_sync    (latch_sync),
        .o_rise    (latch_rise)
    );

    assign unused_sync_levels = clk_sync ^ latch_sync;

    // Data pipe has the same depth as the clk pipe, so the bit seen on a
    // detected clk edge is the one present at the pin edge.
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] data_pipe;
    logic [CHANNELS-1:0]                  data_sync;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_pipe <= '0;
        end else begin
            data_pipe <= {data_pipe[SYNC_STAGES-2:0], i_serial_data};
        end
    end

    assign data_sync = data_pipe[SYNC_STAGES-1];

    logic       shift_go;
    logic       latch_go;
    bus_event_e bus_event;

    assign shift_go  = i_en & clk_rise;
    assign latch_go  = i_en & latch_rise;
    assign bus_event = bus_event_e'({latch_go, shift_go});

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] frame_src;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [SHIFT_WIDTH-1:0] cur;
        assign cur = shift_q[c*SHIFT_WIDTH +: SHIFT_WIDTH];
        if (MSB_FIRST) begin : g_msb_first
            assign shift_d[c*SHIFT_WIDTH +: SHIFT_WIDTH] =
                {cur[SHIFT_WIDTH-2:0], data_sync[c]};
        end else begin : g_lsb_first
            assign shift_d[c*SHIFT_WIDTH +: SHIFT_WIDTH] =
                {data_sync[c], cur[SHIFT_WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (shift_go) begin
            shift_q <= shift_d;
        end
    end

    // A coincident shift is folded in before the frame is captured.
    assign frame_src = shift_go ? shift_d : shift_q;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        count_inc = count_q;
        if (shift_go && (count_q != COUNT_MAX)) begin
            count_inc = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (latch_go) begin
            count_q <= '0;
        end else begin
            count_q <= count_inc;
        end
    end

    logic [DATA_W-1:0] parallel_q;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_q <= '0;
        end else if (latch_go) begin
            parallel_q <= frame_src;
        end
    end

    rx_status_t status_q;
    rx_status_t status_d;

    // An ack coinciding with a latch consumes the old frame, so it is not an overrun.
    always_comb begin
        status_d = status_q;
        case (bus_event)
            EV_LATCH, EV_SHIFT_LATCH: begin
                status_d.valid     = 1'b1;
                status_d.frame_err = (count_inc != COUNT_FULL);
                if (status_q.valid && !i_ack) begin
                    status_d.overrun = 1'b1;
                end
            end
            default: begin
                if (i_ack) begin
                    status_d.valid = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign o_parallel_data = parallel_q;
    assign o_valid         = status_q.valid;
    assign o_frame_err     = status_q.frame_err;
    assign o_overrun       = status_q.overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_display_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_display_receiver
// Brief  : Scoreboard bench driving a 1-ch MSB-first and a 3-ch LSB-first
//          receiver from the same serial clk/latch.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_serial_display_receiver;

    localparam int SW      = 48;
    localparam int CNT_MAX = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         en;
    logic         sclk;
    logic         slatch;
    logic         ack;
    logic         da;
    logic [2:0]   db;
    logic [47:0]  pa;
    logic         va, fa, oa;
    logic [143:0] pb;
    logic         vb, fb, ob;

    serial_display_receiver #(
        .SHIFT_WIDTH (48), .CHANNELS (1), .MSB_FIRST (1'b1), .SYNC_STAGES (2)
    ) dut_a (
        .i_clk (clk), .i_reset_n (reset_n), .i_en (en),
        .i_serial_clk (sclk), .i_serial_latch (slatch), .i_serial_data (da),
        .i_ack (ack), .o_parallel_data (pa), .o_valid (va),
        .o_frame_err (fa), .o_overrun (oa)
    );

    serial_display_receiver #(
        .SHIFT_WIDTH (48), .CHANNELS (3), .MSB_FIRST (1'b0), .SYNC_STAGES (2)
    ) dut_b (
        .i_clk (clk), .i_reset_n (reset_n), .i_en (en),
        .i_serial_clk (sclk), .i_serial_latch (slatch), .i_serial_data (db),
        .i_ack (ack), .o_parallel_data (pb), .o_valid (vb),
        .o_frame_err (fb), .o_overrun (ob)
    );

    typedef struct {
        logic [47:0]  a;
        logic [143:0] b;
        logic         ferr;
        logic         ovr;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] m_a;
    logic [47:0] m_b [3];
    int          m_cnt;
    logic        m_valid;
    logic        m_ovr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_a = '0;
        for (int c = 0; c < 3; c++) m_b[c] = '0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_shift(input logic a, input logic [2:0] b);
        m_a = {m_a[46:0], a};
        for (int c = 0; c < 3; c++) m_b[c] = {b[c], m_b[c][47:1]};
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic model_latch(input bit ack_same);
        exp_t e;
        e.ferr = (m_cnt != SW);
        if (m_valid && !ack_same) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_cnt   = 0;
        e.a     = m_a;
        e.b     = {m_b[2], m_b[1], m_b[0]};
        e.ovr   = m_ovr;
        sb.push_back(e);
    endtask

    task automatic check_outputs(input exp_t e);
        check("a_data", pa, e.a);
        check("b_data", pb, e.b);
        check("a_valid", va, 1'b1);
        check("b_valid", vb, 1'b1);
        check("a_ferr", fa, e.ferr);
        check("b_ferr", fb, e.ferr);
        check("a_ovr", oa, e.ovr);
        check("b_ovr", ob, e.ovr);
    endtask

    task automatic send_bit(input logic a, input logic [2:0] b);
        da = a;
        db = b;
        tick(4);
        sclk = 1'b1;
        if (en) model_shift(a, b);
        tick(4);
        sclk = 1'b0;
    endtask

    // Optionally raises serial clk together with the latch, carrying one last bit.
    task automatic do_latch(input bit with_bit, input logic a, input logic [2:0] b, input bit ack_same);
        logic old_valid;
        exp_t e;
        old_valid = m_valid;
        if (with_bit) begin
            da = a;
            db = b;
            tick(4);
            sclk = 1'b1;
        end
        slatch = 1'b1;
        if (en) begin
            if (with_bit) model_shift(a, b);
            model_latch(ack_same);
        end
        tick(2);
        check("valid_before_latency", va, old_valid);
        if (ack_same) ack = 1'b1;
        tick(1);
        ack = 1'b0;
        if (en) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                check_outputs(e);
            end
        end else begin
            check("valid_disabled", va, m_valid);
        end
        tick(3);
        slatch = 1'b0;
        sclk   = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input int n, input logic [47:0] p_a, input logic [47:0] p_1,
                              input logic [47:0] p_2, input bit end_with_latch);
        logic       a;
        logic [2:0] b;
        for (int k = 0; k < n; k++) begin
            a = p_a[(n - 1 - k) % 48];
            b = {p_2[k % 48], p_1[k % 48], a};
            if (end_with_latch && k == n - 1) do_latch(1'b1, a, b, 1'b0);
            else send_bit(a, b);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        m_valid = 1'b0;
        check("ack_a_valid", va, 1'b0);
        check("ack_b_valid", vb, 1'b0);
        check("ack_a_ovr", oa, m_ovr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_data"}, pa, '0);
        check({tag, "_b_data"}, pb, '0);
        check({tag, "_flags"}, {va, fa, oa, vb, fb, ob}, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b1;
        sclk    = 1'b0;
        slatch  = 1'b0;
        ack     = 1'b0;
        da      = 1'b0;
        db      = 3'b000;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(4);
        check_all_zero("reset");

        // Full MSB-first frame, plus LSB-first per-channel references.
        send_frame(48, 48'hA5A5_0000_FFFF, 48'h1234_5678_9ABC, 48'hF0E1_D2C3_B4A5, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        check("t1_const_a", pa, 48'hA5A5_0000_FFFF);
        check("t5_rev_ch0", pb[47:0], rev48(48'hA5A5_0000_FFFF));
        check("t5_ch1", pb[95:48], 48'h1234_5678_9ABC);
        check("t5_ch2", pb[143:96], 48'hF0E1_D2C3_B4A5);
        do_ack();

        // Short and long frames.
        send_frame(47, 48'h0123_4567_89AB, 48'hDEAD_BEEF_0001, 48'h5555_AAAA_3333, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        do_ack();
        send_frame(49, 48'hC3C3_1111_7E7E, 48'h0F0F_0F0F_0F0F, 48'h8001_8001_8001, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        check("t2_last48", pa, 48'hC3C3_1111_7E7E);
        do_ack();

        // Coincident clk+latch on bit 48, then latch with same-cycle ack.
        send_frame(48, 48'h9876_5432_10FE, 48'h0000_FFFF_0000, 48'h1357_9BDF_2468, 1'b1);
        check("t4_bit48", pa, 48'h9876_5432_10FE);
        send_frame(48, 48'h2468_ACE0_1357, 48'hAAAA_5555_AAAA, 48'h7777_8888_9999, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b1);
        do_ack();

        // Bit counter saturates instead of wrapping back to a "good" 48.
        send_frame(112, 48'h6B6B_6B6B_6B6B, 48'h1111_2222_3333, 48'h4444_5555_6666, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        do_ack();

        // Overrun: two frames without ack.
        send_frame(48, 48'h1111_1111_1111, 48'h2222_2222_2222, 48'h3333_3333_3333, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        send_frame(48, 48'hBEEF_CAFE_F00D, 48'h0BAD_F00D_0001, 48'hFACE_B00C_1234, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        check("t3_second", pa, 48'hBEEF_CAFE_F00D);
        do_ack();

        // Disabled: edges ignored, no false edge when re-enabled mid-high.
        en = 1'b0;
        send_frame(5, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        da   = 1'b1;
        db   = 3'b111;
        tick(4);
        sclk = 1'b1;
        tick(4);
        en = 1'b1;
        tick(4);
        sclk = 1'b0;
        send_frame(48, 48'h0F1E_2D3C_4B5A, 48'h6978_8796_A5B4, 48'hC3D2_E1F0_0F1E, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        do_ack();

        // Reset mid-frame with en toggling.
        send_frame(20, 48'hABCD_EF01_2345, 48'h5A5A_5A5A_5A5A, 48'hA5A5_A5A5_A5A5, 1'b0);
        en = 1'b0;
        send_frame(3, 48'h0, 48'h0, 48'h0, 1'b0);
        en = 1'b1;
        send_frame(2, 48'h3, 48'h3, 48'h3, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        tick(2);
        reset_n = 1'b1;
        tick(4);
        send_frame(28, 48'h0000_0ABC_DEF1, 48'h0000_0123_4567, 48'h0000_0FED_CBA9, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        do_ack();
        send_frame(48, 48'h5EED_1234_ABCD, 48'h7E57_0000_FFFF, 48'h0001_0002_0003, 1'b0);
        do_latch(1'b0, 1'b0, 3'b000, 1'b0);
        check("t6_clean", {fa, pa}, {1'b0, 48'h5EED_1234_ABCD});
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
